// File: rtl/uitpg_mode_ctrl_if.sv
// Control bundle between the pattern-mode sequencer and its user / timing side.
// master drives the requests and vsync, slave is the sequencer.
interface uitpg_mode_ctrl_if;
    logic        I_vs;
    logic        I_auto_en;
    logic        I_next;
    logic        I_prev;
    logic        I_sel_load;
    logic [3:0]  I_sel_val;
    logic [3:0]  O_pat_sel;
    logic        O_pat_upd;
    logic        O_req_pend;
    logic [15:0] O_frame_cnt;

    modport master (
        output I_vs, I_auto_en, I_next, I_prev, I_sel_load, I_sel_val,
        input  O_pat_sel, O_pat_upd, O_req_pend, O_frame_cnt
    );

    modport slave (
        input  I_vs, I_auto_en, I_next, I_prev, I_sel_load, I_sel_val,
        output O_pat_sel, O_pat_upd, O_req_pend, O_frame_cnt
    );
endinterface

// File: rtl/uitpg_mode_ctrl.sv
// Pattern-mode sequencer: picks the TPG pattern index and only changes it on a
// vsync rising edge, with timed auto-cycling and latched manual requests.
module uitpg_mode_ctrl #(
    parameter int NUM_PATTERNS = 16,
    parameter int DWELL_FRAMES = 60,
    parameter int DWELL_W      = 8
) (
    input  logic              I_ctl_clk,
    input  logic              I_ctl_rst,
    uitpg_mode_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {S_INIT, S_AUTO, S_MAN} state_t;

    localparam logic [3:0]         MAX_SEL    = 4'(NUM_PATTERNS - 1);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_FRAMES - 1);

    state_t             state_q, state_d;
    logic               vs_q;
    logic [3:0]         sel_q, sel_d;
    logic               upd_q, upd_d;
    logic               pend_q, pend_d;
    logic [3:0]         tgt_q, tgt_d;
    logic [15:0]        frame_q, frame_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    logic       fs;
    logic       req;
    logic [3:0] base, req_val, adv_val;

    assign fs = bus.I_vs & ~vs_q;

    // Requests stack on an outstanding target so repeated pulses accumulate.
    always_comb begin
        base    = pend_q ? tgt_q : sel_q;
        req     = bus.I_sel_load | bus.I_next | bus.I_prev;
        req_val = base;
        if (bus.I_sel_load)
            req_val = (bus.I_sel_val > MAX_SEL) ? MAX_SEL : bus.I_sel_val;
        else if (bus.I_next)
            req_val = (base == MAX_SEL) ? 4'd0 : base + 4'd1;
        else if (bus.I_prev)
            req_val = (base == 4'd0) ? MAX_SEL : base - 4'd1;
        adv_val = (sel_q == MAX_SEL) ? 4'd0 : sel_q + 4'd1;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        pend_d  = pend_q;
        tgt_d   = tgt_q;
        frame_d = frame_q;
        dwell_d = dwell_q;

        if (fs) begin
            frame_d = frame_q + 16'd1;
            case (state_q)
                S_AUTO: begin
                    if (pend_q) begin
                        sel_d   = tgt_q;
                        pend_d  = 1'b0;
                        dwell_d = '0;
                    end else if (dwell_q == DWELL_LAST) begin
                        sel_d   = adv_val;
                        dwell_d = '0;
                    end else begin
                        dwell_d = dwell_q + 1'b1;
                    end
                    if (!bus.I_auto_en) begin
                        state_d = S_MAN;
                        dwell_d = '0;
                    end
                end
                default: begin
                    // S_INIT and S_MAN: only pending requests move the select.
                    if (pend_q) begin
                        sel_d  = tgt_q;
                        pend_d = 1'b0;
                    end
                    dwell_d = '0;
                    state_d = bus.I_auto_en ? S_AUTO : S_MAN;
                end
            endcase
        end

        // A request landing on the fs cycle is held for the following frame.
        if (req) begin
            pend_d = 1'b1;
            tgt_d  = req_val;
        end

        upd_d = (sel_d != sel_q);
    end

    always_ff @(posedge I_ctl_clk) begin
        if (I_ctl_rst) begin
            state_q <= S_INIT;
            vs_q    <= 1'b1;
            sel_q   <= '0;
            upd_q   <= 1'b0;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
            frame_q <= '0;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= bus.I_vs;
            sel_q   <= sel_d;
            upd_q   <= upd_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
            frame_q <= frame_d;
            dwell_q <= dwell_d;
        end
    end

    assign bus.O_pat_sel   = sel_q;
    assign bus.O_pat_upd   = upd_q;
    assign bus.O_req_pend  = pend_q;
    assign bus.O_frame_cnt = frame_q;
endmodule
